// File: rtl/galvo_scan_ctrl_pkg.sv
// Shared constants for the galvo raster scan controller.
// State encoding, default widths and the per-pixel position step.
package galvo_scan_ctrl_pkg;

  localparam int POS_W_DEF    = 11;
  localparam int SETTLE_W_DEF = 8;
  localparam int PIXEL_SIZE   = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MOVE   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_READY  = 2'd3
  } scan_state_e;

endpackage

// File: rtl/galvo_scan_ctrl_pos_counter.sv
// Wrap-around H/V raster position counter.
// Latches the frame size on load and flags the last pixel / last line.
module scan_pos_counter
  import galvo_scan_ctrl_pkg::*;
#(
  parameter int POS_W = POS_W_DEF
) (
  input  logic             clk_adc,
  input  logic             rst_adc,
  input  logic             load,
  input  logic [POS_W-1:0] h_size,
  input  logic [POS_W-1:0] v_size,
  input  logic             step,
  output logic [POS_W-1:0] galvoh,
  output logic [POS_W-1:0] galvov,
  output logic             last_pix,
  output logic             last_line
);

  logic [POS_W-1:0] h_max_q;
  logic [POS_W-1:0] v_max_q;

  // a size of 0 scans like a size of 1
  function automatic logic [POS_W-1:0] size_max(
    input logic [POS_W-1:0] sz
  );
    return (sz == '0) ? '0 : sz - POS_W'(1);
  endfunction

  assign last_pix  = (galvoh == h_max_q);
  assign last_line = (galvov == v_max_q);

  // latch sizes on load, advance in raster order on step
  always_ff @(posedge clk_adc) begin
    if (rst_adc) begin
      h_max_q <= '0;
      v_max_q <= '0;
      galvoh  <= '0;
      galvov  <= '0;
    end else if (load) begin
      h_max_q <= size_max(h_size);
      v_max_q <= size_max(v_size);
      galvoh  <= '0;
      galvov  <= '0;
    end else if (step) begin
      if (last_pix) begin
        galvoh <= '0;
        if (!last_line)
          galvov <= galvov + POS_W'(PIXEL_SIZE);
      end else begin
        galvoh <= galvoh + POS_W'(PIXEL_SIZE);
      end
    end
  end

endmodule

// File: rtl/galvo_scan_ctrl.sv
// Galvo raster scan controller: move, settle, then offer each pixel.
// Handshakes with the galvo SPI driver and the master pixel tick.
module galvo_scan_ctrl
  import galvo_scan_ctrl_pkg::*;
#(
  parameter int POS_W    = POS_W_DEF,
  parameter int SETTLE_W = SETTLE_W_DEF
) (
  input  logic                clk_adc,
  input  logic                rst_adc,
  input  logic                start,
  input  logic                abort,
  input  logic [POS_W-1:0]    h_size,
  input  logic [POS_W-1:0]    v_size,
  input  logic [SETTLE_W-1:0] settle_cycles,
  input  logic                galvo_go,
  input  logic                galvo_spi_done,
  output logic                spi_start,
  output logic [POS_W-1:0]    galvoh,
  output logic [POS_W-1:0]    galvov,
  output logic                pixel_en,
  output logic                line_end,
  output logic                frame_done,
  output logic                busy,
  output logic                overrun
);

  scan_state_e         state_q;
  scan_state_e         state_d;
  logic [SETTLE_W-1:0] settle_q;
  logic [SETTLE_W-1:0] settle_d;
  logic [SETTLE_W-1:0] cnt_q;
  logic [SETTLE_W-1:0] cnt_d;

  logic spi_start_d;
  logic pixel_en_d;
  logic line_end_d;
  logic frame_done_d;
  logic busy_d;
  logic overrun_d;

  logic start_ok;
  logic done_ok;
  logic go_ok;
  logic frame_end;
  logic step;
  logic last_pix;
  logic last_line;

  // done is only trusted after the request cycle itself
  assign start_ok  = (state_q == ST_IDLE) && start && !abort;
  assign done_ok   = (state_q == ST_MOVE) && galvo_spi_done
                     && !spi_start;
  assign go_ok     = (state_q == ST_READY) && galvo_go && !abort;
  assign frame_end = go_ok && last_pix && last_line;
  assign step      = go_ok && !frame_end;

  scan_pos_counter #(
    .POS_W(POS_W)
  ) u_pos (
    .clk_adc  (clk_adc),
    .rst_adc  (rst_adc),
    .load     (start_ok),
    .h_size   (h_size),
    .v_size   (v_size),
    .step     (step),
    .galvoh   (galvoh),
    .galvov   (galvov),
    .last_pix (last_pix),
    .last_line(last_line)
  );

  // state, counters and all outputs are registered here
  always_ff @(posedge clk_adc) begin
    if (rst_adc) begin
      state_q    <= ST_IDLE;
      settle_q   <= '0;
      cnt_q      <= '0;
      spi_start  <= 1'b0;
      pixel_en   <= 1'b0;
      line_end   <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state_q    <= state_d;
      settle_q   <= settle_d;
      cnt_q      <= cnt_d;
      spi_start  <= spi_start_d;
      pixel_en   <= pixel_en_d;
      line_end   <= line_end_d;
      frame_done <= frame_done_d;
      busy       <= busy_d;
      overrun    <= overrun_d;
    end
  end

  // next state; abort overrides every transition
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start)
            state_d = ST_MOVE;
        end
        ST_MOVE: begin
          if (done_ok)
            state_d = (settle_q == '0) ? ST_READY : ST_SETTLE;
        end
        ST_SETTLE: begin
          if (cnt_q <= SETTLE_W'(1))
            state_d = ST_READY;
        end
        ST_READY: begin
          if (galvo_go)
            state_d = frame_end ? ST_IDLE : ST_MOVE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // next values of outputs and datapath registers
  always_comb begin
    settle_d     = start_ok ? settle_cycles : settle_q;
    cnt_d        = cnt_q;
    if (done_ok)
      cnt_d = settle_q;
    else if (state_q == ST_SETTLE && cnt_q != '0)
      cnt_d = cnt_q - SETTLE_W'(1);
    spi_start_d  = (state_d == ST_MOVE) && (state_q != ST_MOVE);
    pixel_en_d   = (state_d == ST_READY);
    busy_d       = (state_d != ST_IDLE);
    line_end_d   = go_ok && last_pix;
    frame_done_d = frame_end;
    overrun_d    = overrun;
    if (start_ok)
      overrun_d = 1'b0;
    else if (galvo_go && (state_q == ST_MOVE ||
                          state_q == ST_SETTLE))
      overrun_d = 1'b1;
  end

endmodule

// File: tb/tb_galvo_scan_ctrl.sv
// Directed self-checking bench for galvo_scan_ctrl.
// Inputs change and outputs are checked on the falling clock edge.
module tb_galvo_scan_ctrl;

  localparam int PW = 11;
  localparam int SW = 8;

  logic          clk_adc = 1'b0;
  logic          rst_adc;
  logic          start;
  logic          abort;
  logic [PW-1:0] h_size;
  logic [PW-1:0] v_size;
  logic [SW-1:0] settle_cycles;
  logic          galvo_go;
  logic          galvo_spi_done;
  logic          spi_start;
  logic [PW-1:0] galvoh;
  logic [PW-1:0] galvov;
  logic          pixel_en;
  logic          line_end;
  logic          frame_done;
  logic          busy;
  logic          overrun;

  int total = 0;
  int bad   = 0;
  int n;

  galvo_scan_ctrl #(
    .POS_W   (PW),
    .SETTLE_W(SW)
  ) dut (
    .clk_adc       (clk_adc),
    .rst_adc       (rst_adc),
    .start         (start),
    .abort         (abort),
    .h_size        (h_size),
    .v_size        (v_size),
    .settle_cycles (settle_cycles),
    .galvo_go      (galvo_go),
    .galvo_spi_done(galvo_spi_done),
    .spi_start     (spi_start),
    .galvoh        (galvoh),
    .galvov        (galvov),
    .pixel_en      (pixel_en),
    .line_end      (line_end),
    .frame_done    (frame_done),
    .busy          (busy),
    .overrun       (overrun)
  );

  always #5 clk_adc = ~clk_adc;

  task automatic tick();
    @(negedge clk_adc);
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".spi_start"}, 32'(spi_start), 0);
    chk({tag, ".pixel_en"}, 32'(pixel_en), 0);
    chk({tag, ".line_end"}, 32'(line_end), 0);
    chk({tag, ".frame_done"}, 32'(frame_done), 0);
    chk({tag, ".busy"}, 32'(busy), 0);
    chk({tag, ".overrun"}, 32'(overrun), 0);
    chk({tag, ".galvoh"}, 32'(galvoh), 0);
    chk({tag, ".galvov"}, 32'(galvov), 0);
  endtask

  task automatic go_start(input int h, input int v, input int s);
    h_size        = PW'(h);
    v_size        = PW'(v);
    settle_cycles = SW'(s);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // one pixel from its spi_start cycle to the next pixel's
  task automatic pixel(input int eh, input int ev, input int es,
                       input logic ele, input logic efd);
    chk("pix.spi_start", 32'(spi_start), 1);
    chk("pix.galvoh", 32'(galvoh), eh);
    chk("pix.galvov", 32'(galvov), ev);
    chk("pix.busy", 32'(busy), 1);
    tick();
    chk("pix.spi_pulse", 32'(spi_start), 0);
    tick();
    galvo_spi_done = 1'b1;
    tick();
    galvo_spi_done = 1'b0;
    n = 0;
    while (!pixel_en && n < 400) begin
      tick();
      n++;
    end
    chk("pix.settle_len", n, es);
    tick();
    chk("pix.pixel_en", 32'(pixel_en), 1);
    galvo_go = 1'b1;
    tick();
    galvo_go = 1'b0;
    chk("pix.pixel_drop", 32'(pixel_en), 0);
    chk("pix.line_end", 32'(line_end), 32'(ele));
    chk("pix.frame_done", 32'(frame_done), 32'(efd));
    chk("pix.busy_after", 32'(busy), 32'(!efd));
  endtask

  initial begin
    rst_adc        = 1'b1;
    start          = 1'b0;
    abort          = 1'b0;
    h_size         = '0;
    v_size         = '0;
    settle_cycles  = '0;
    galvo_go       = 1'b0;
    galvo_spi_done = 1'b0;
    tick();
    tick();
    rst_adc = 1'b0;
    chk_zero("reset");

    galvo_go = 1'b1;
    tick();
    galvo_go = 1'b0;
    chk("idle_go.busy", 32'(busy), 0);
    chk("idle_go.overrun", 32'(overrun), 0);

    // 3x2 frame, settle 4
    go_start(3, 2, 4);
    pixel(0, 0, 4, 0, 0);
    pixel(1, 0, 4, 0, 0);
    pixel(2, 0, 4, 1, 0);
    pixel(0, 1, 4, 0, 0);
    pixel(1, 1, 4, 0, 0);
    pixel(2, 1, 4, 1, 1);
    chk("frameA.spi_start", 32'(spi_start), 0);
    chk("frameA.galvoh", 32'(galvoh), 2);
    chk("frameA.galvov", 32'(galvov), 1);
    tick();
    chk("frameA.fd_pulse", 32'(frame_done), 0);

    // settle 0; early done ignored; start while busy ignored
    go_start(1, 1, 0);
    chk("s0.spi_start", 32'(spi_start), 1);
    galvo_spi_done = 1'b1;
    tick();
    galvo_spi_done = 1'b0;
    chk("s0.early_done", 32'(pixel_en), 0);
    chk("s0.busy", 32'(busy), 1);
    galvo_spi_done = 1'b1;
    start  = 1'b1;
    h_size = PW'(5);
    tick();
    galvo_spi_done = 1'b0;
    start = 1'b0;
    chk("s0.pixel_en", 32'(pixel_en), 1);
    chk("s0.no_restart", 32'(spi_start), 0);
    galvo_go = 1'b1;
    tick();
    galvo_go = 1'b0;
    chk("s0.frame_done", 32'(frame_done), 1);
    chk("s0.line_end", 32'(line_end), 1);
    chk("s0.busy_end", 32'(busy), 0);

    // longest settle
    go_start(1, 1, 255);
    pixel(0, 0, 255, 1, 1);

    // overrun in SETTLE, then abort in SETTLE of (2,1)
    go_start(3, 2, 4);
    pixel(0, 0, 4, 0, 0);
    chk("ovr.galvoh", 32'(galvoh), 1);
    tick();
    tick();
    galvo_spi_done = 1'b1;
    tick();
    galvo_spi_done = 1'b0;
    galvo_go = 1'b1;
    tick();
    galvo_go = 1'b0;
    chk("ovr.flag", 32'(overrun), 1);
    chk("ovr.hold", 32'(galvoh), 1);
    chk("ovr.pixel_en", 32'(pixel_en), 0);
    n = 0;
    while (!pixel_en && n < 400) begin
      tick();
      n++;
    end
    chk("ovr.settle_rest", n, 3);
    chk("ovr.hold2", 32'(galvoh), 1);
    tick();
    galvo_go = 1'b1;
    tick();
    galvo_go = 1'b0;
    pixel(2, 0, 4, 1, 0);
    pixel(0, 1, 4, 0, 0);
    pixel(1, 1, 4, 0, 0);
    chk("abt.galvoh", 32'(galvoh), 2);
    chk("abt.galvov", 32'(galvov), 1);
    tick();
    tick();
    galvo_spi_done = 1'b1;
    tick();
    galvo_spi_done = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abt.busy", 32'(busy), 0);
    chk("abt.pixel_en", 32'(pixel_en), 0);
    chk("abt.frame_done", 32'(frame_done), 0);
    chk("abt.galvoh", 32'(galvoh), 2);
    chk("abt.galvov", 32'(galvov), 1);
    chk("abt.overrun", 32'(overrun), 1);
    tick();
    chk("abt.fd_later", 32'(frame_done), 0);
    chk("abt.spi_later", 32'(spi_start), 0);
    go_start(3, 2, 4);
    chk("clr.overrun", 32'(overrun), 0);
    chk("clr.spi_start", 32'(spi_start), 1);
    chk("clr.galvoh", 32'(galvoh), 0);
    chk("clr.galvov", 32'(galvov), 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abt_move.busy", 32'(busy), 0);
    chk("abt_move.spi", 32'(spi_start), 0);

    // start with abort, then zero-size frame
    h_size = '0;
    v_size = '0;
    settle_cycles = SW'(1);
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("sa.busy", 32'(busy), 0);
    chk("sa.spi_start", 32'(spi_start), 0);
    go_start(0, 0, 1);
    pixel(0, 0, 1, 1, 1);

    // reset in MOVE
    go_start(3, 2, 4);
    pixel(0, 0, 4, 0, 0);
    galvo_go = 1'b1;
    tick();
    galvo_go = 1'b0;
    chk("rst.pre_ovr", 32'(overrun), 1);
    chk("rst.pre_h", 32'(galvoh), 1);
    rst_adc = 1'b1;
    tick();
    rst_adc = 1'b0;
    chk_zero("rst_move");
    galvo_spi_done = 1'b1;
    tick();
    galvo_spi_done = 1'b0;
    chk("rst.late_busy", 32'(busy), 0);
    chk("rst.late_pix", 32'(pixel_en), 0);
    chk("rst.late_spi", 32'(spi_start), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/galvo_scan_ctrl.md
GALVO_SCAN_CTRL -- requirements
Module: galvo_scan_ctrl

Interface
REQ-001 Parameter POS_W, default 11, galvo position width per axis.
REQ-002 Parameter SETTLE_W, default 8, settle counter width.
REQ-003 clk_adc  in  1  ADC sample clock; the only clock.
REQ-004 rst_adc  in  1  reset, synchronous, active-high.
REQ-005 start  in  1  single-cycle pulse; begins a frame.
REQ-006 abort  in  1  single-cycle pulse; ends the frame immediately.
REQ-007 h_size  in  POS_W  pixels per line; sampled on accepted start.
REQ-008 v_size  in  POS_W  lines per frame; sampled on accepted start.
REQ-009 settle_cycles  in  SETTLE_W  wait after SPI done; sampled on accepted start.
REQ-010 galvo_go  in  1  pixel tick from the master controller.
REQ-011 galvo_spi_done  in  1  single-cycle pulse from the galvo SPI driver.
REQ-012 spi_start  out  1  single-cycle request to the SPI driver to write galvoh/galvov.
REQ-013 galvoh  out  POS_W  commanded horizontal position.
REQ-014 galvov  out  POS_W  commanded vertical position.
REQ-015 pixel_en  out  1  galvo settled; the current pixel is valid to sample.
REQ-016 line_end  out  1  pulse on the last pixel of each line.
REQ-017 frame_done  out  1  pulse on completion of the frame.
REQ-018 busy  out  1  high in every state except IDLE.
REQ-019 overrun  out  1  sticky flag: a galvo_go arrived before the galvo settled.

Function
REQ-020 States: IDLE, MOVE, SETTLE and READY; the state register and all outputs are registered.
REQ-021 IDLE: start latches the sizes, clears galvoh and galvov to 0, and moves to MOVE.
REQ-022 A latched h_size or v_size of 0 is treated as 1.
REQ-023 spi_start is high exactly on the first cycle of each MOVE entry.
REQ-024 galvo_spi_done is accepted only on cycles after the spi_start cycle.
REQ-025 MOVE: an accepted done moves to SETTLE and loads the counter with settle_cycles.
REQ-026 MOVE: if settle_cycles is 0, an accepted done moves directly to READY.
REQ-027 SETTLE: the counter decrements each cycle; the cycle it reads 1 moves to READY, giving exactly settle_cycles SETTLE cycles.
REQ-028 READY: pixel_en is high; the block waits for galvo_go.
REQ-029 READY with galvo_go: pixel_en drops on the next cycle.
REQ-030 READY with galvo_go, galvoh < h_size-1: galvoh increments, then MOVE.
REQ-031 READY with galvo_go, galvoh = h_size-1 and galvov < v_size-1: line_end pulses, galvoh wraps to 0, galvov increments, then MOVE.
REQ-032 READY with galvo_go at the last pixel: line_end and frame_done pulse together, then IDLE; positions are held.
REQ-033 galvo_go in MOVE or SETTLE sets overrun and is otherwise ignored.
REQ-034 overrun clears only on an accepted start or on reset.
REQ-035 galvo_go in IDLE is ignored.
REQ-036 start while busy is ignored.
REQ-037 abort in any state goes to IDLE on the next cycle: pixel_en drops, no frame_done, positions held.
REQ-038 An abort in flight cancels any spi_start due that cycle.
REQ-039 start and abort in the same cycle: abort wins, and the block stays or goes to IDLE.
REQ-040 Latched sizes do not change mid-frame.

Reset
REQ-041 On rst_adc: state goes to IDLE.
REQ-042 On rst_adc: galvoh, galvov, the counter and the latched sizes go to 0.
REQ-043 On rst_adc: spi_start, pixel_en, line_end, frame_done, busy and overrun go to 0.
REQ-044 Reset mid-frame behaves as abort, and additionally clears positions and overrun.

Structure
REQ-045 The state encoding enum and POS_W/SETTLE_W defaults live in the shared constants package, next to the PIXEL_SIZE constant.
REQ-046 One sub-module: scan_pos_counter, the wrap-around H/V position counter with last-pixel/last-line flags.
REQ-047 No CDC inside the block; the instantiating level synchronizes the control-domain fields.

Verification
REQ-048 h=3, v=2, settle=4, done 2 cycles after each spi_start, galvo_go 1 cycle after pixel_en -> 6 spi_starts; positions (0,0)(1,0)(2,0)(0,1)(1,1)(2,1); line_end twice; one frame_done.
REQ-049 settle=0 -> pixel_en asserts the cycle after done; settle=255 -> exactly 255 SETTLE cycles.
REQ-050 galvo_go during SETTLE of pixel (1,0) -> overrun=1 and the position is not advanced; the next start clears overrun.
REQ-051 abort in SETTLE of pixel (2,1) -> IDLE next cycle, busy=0, galvoh=2, galvov=1, no frame_done.
REQ-052 start+abort same cycle from IDLE, then h=0/v=0 frame -> no frame first; then a single pixel (0,0) with frame_done.
REQ-053 rst_adc asserted in MOVE -> all outputs 0 next cycle; done arriving afterwards is ignored.
